// File: rtl/int_ctl.sv
// Interrupt controller for the 65C02 microcoded core: synchronises, masks and prioritises IRQ/NMI.
// Latency: SYNC_STAGES+1 cycles from pin to pending/nmi_pend; int_req one cycle later (registered).
// Backpressure: none; a taken interrupt is held in TAKEN until vec_fetch or TIMEOUT cycles elapse.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   irq_src[NUM_IRQ]    asynchronous level IRQ requests (active-high)
//   nmi_in              asynchronous NMI, rising-edge triggered
//   mask_we/mask_wdata  mask register write (1 = source enabled)
//   sync                sequencer is decoding a new instruction this cycle
//   I_flag              processor I flag
//   vec_fetch           one-cycle pulse while the core reads the vector low byte
//   int_req             registered request to the sequencer irq input
//   i_eff               effective I flag to the sequencer (cleared while an NMI waits)
//   vec_sel             00 IRQ/BRK $FFFE, 01 NMI $FFFA, 10 RESET $FFFC
//   irq_id              index of the IRQ being serviced (0 for NMI), frozen while busy
//   pending             synchronised irq_src & mask
//   busy                an interrupt has been taken and awaits its vector fetch
//   timeout             sticky flag: a taken interrupt never saw its vector fetch
module int_ctl #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               nmi_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               sync,
  input  logic               I_flag,
  input  logic               vec_fetch,
  output logic               int_req,
  output logic               i_eff,
  output logic [1:0]         vec_sel,
  output logic [3:0]         irq_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic               busy,
  output logic               timeout
);

  localparam logic [1:0] SEL_IRQ = 2'b00;
  localparam logic [1:0] SEL_NMI = 2'b01;
  localparam logic [1:0] SEL_RST = 2'b10;
  localparam logic [3:0] TO_CNT  = 4'(TIMEOUT);

  typedef enum logic {
    IDLE  = 1'b0,
    TAKEN = 1'b1
  } state_t;

  state_t state, state_d;

  // ---------------------------------------------------------------------------
  // Input synchronisers. nmi_prev is one stage beyond the chain so that a
  // rising edge is seen as (last stage & ~nmi_prev).
  // ---------------------------------------------------------------------------
  logic [NUM_IRQ-1:0]     irq_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] nmi_sync;
  logic                   nmi_prev;
  logic                   nmi_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) irq_sync[i] <= '0;
      nmi_sync <= '0;
      nmi_prev <= 1'b0;
    end else begin
      irq_sync[0] <= irq_src;
      for (int i = 1; i < SYNC_STAGES; i++) irq_sync[i] <= irq_sync[i-1];
      nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmi_in};
      nmi_prev <= nmi_sync[SYNC_STAGES-1];
    end
  end

  assign nmi_edge = nmi_sync[SYNC_STAGES-1] & ~nmi_prev;

  // ---------------------------------------------------------------------------
  // Mask and pending. pending is registered from the mask register, so a mask
  // write is reflected in pending one cycle after the mask itself updates.
  // ---------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask    <= '0;
      pending <= '0;
    end else begin
      if (mask_we) mask <= mask_wdata;
      pending <= irq_sync[SYNC_STAGES-1] & mask;
    end
  end

  // Lowest-index pending IRQ wins; scan from the top so the last hit is lowest.
  logic [3:0] prio_id;

  always_comb begin
    prio_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) prio_id = 4'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic       nmi_pend, nmi_pend_d;
  logic       nmi_clr;
  logic       int_req_d;
  logic [1:0] vec_sel_d;
  logic [3:0] irq_id_d;
  logic [3:0] cnt, cnt_d;
  logic       timeout_d;

  always_comb begin
    state_d   = state;
    vec_sel_d = vec_sel;
    irq_id_d  = irq_id;
    cnt_d     = cnt;
    timeout_d = timeout;
    nmi_clr   = 1'b0;

    case (state)
      IDLE: begin
        // A vector fetch outside TAKEN is BRK or the reset sequence; once it
        // has been served the default vector becomes IRQ/BRK.
        if (vec_fetch) vec_sel_d = SEL_IRQ;
        if (sync && int_req) begin
          state_d   = TAKEN;
          vec_sel_d = nmi_pend ? SEL_NMI : SEL_IRQ;
          irq_id_d  = nmi_pend ? 4'd0 : prio_id;
          cnt_d     = '0;
        end
      end
      TAKEN: begin
        if (vec_fetch) begin
          nmi_clr   = (vec_sel == SEL_NMI);
          vec_sel_d = SEL_IRQ;
          state_d   = IDLE;
        end else if (cnt == TO_CNT) begin
          // Abandon the service; a still-pending NMI is simply retried.
          timeout_d = 1'b1;
          vec_sel_d = SEL_IRQ;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge arriving on the clearing cycle must survive the clear.
  assign nmi_pend_d = nmi_edge | (nmi_pend & ~nmi_clr);

  // Looking at the next state keeps int_req low in the first TAKEN cycle, and
  // masking the NMI being cleared avoids a stale request right after service.
  assign int_req_d = (state_d == IDLE) &
                     ((nmi_pend & ~nmi_clr) | ((|pending) & ~I_flag));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      nmi_pend <= 1'b0;
      int_req  <= 1'b0;
      vec_sel  <= SEL_RST;
      irq_id   <= '0;
      cnt      <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      nmi_pend <= nmi_pend_d;
      int_req  <= int_req_d;
      vec_sel  <= vec_sel_d;
      irq_id   <= irq_id_d;
      cnt      <= cnt_d;
      timeout  <= timeout_d;
    end
  end

  assign busy = (state == TAKEN);

  // NMI is not maskable, so while one waits the sequencer must not gate it
  // with I.
  assign i_eff = reset ? I_flag : (I_flag & ~((state == IDLE) & nmi_pend));

endmodule

// File: tb/tb_int_ctl.sv
// Directed testbench for int_ctl with hand-computed expectations.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the next.
// Backpressure: not applicable; every wait is a fixed cycle count plus a global time guard.
module tb_int_ctl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irq_src = '0;
  logic       nmi_in = 1'b0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = '0;
  logic       sync = 1'b0;
  logic       I_flag = 1'b1;
  logic       vec_fetch = 1'b0;
  logic       int_req;
  logic       i_eff;
  logic [1:0] vec_sel;
  logic [3:0] irq_id;
  logic [7:0] pending;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  int_ctl #(.NUM_IRQ(8), .SYNC_STAGES(2), .TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .nmi_in     (nmi_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .sync       (sync),
    .I_flag     (I_flag),
    .vec_fetch  (vec_fetch),
    .int_req    (int_req),
    .i_eff      (i_eff),
    .vec_sel    (vec_sel),
    .irq_id     (irq_id),
    .pending    (pending),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse on sync
  task automatic do_sync();
    sync = 1'b1;
    step();
    sync = 1'b0;
  endtask

  task automatic do_fetch();
    vec_fetch = 1'b1;
    step();
    vec_fetch = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (3) step();
    chk("rst_int_req", int_req, 0);
    chk("rst_vec_sel", vec_sel, 2'b10);
    chk("rst_irq_id",  irq_id, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_pending", pending, 0);
    chk("rst_i_eff",   i_eff, 1);
    reset = 1'b0;
    step();

    // ---------------- vector fetch in IDLE ----------------
    chk("idle_vsel_before", vec_sel, 2'b10);
    do_fetch();
    chk("idle_vsel_after", vec_sel, 2'b00);
    chk("idle_int_req", int_req, 0);

    // ---------------- single IRQ, latency ----------------
    mask_wdata = 8'h0C;
    mask_we    = 1'b1;
    step();
    mask_we = 1'b0;
    I_flag  = 1'b0;
    irq_src = 8'h08;
    repeat (3) step();
    chk("irq_pending", pending, 8'h08);
    chk("irq_req_early", int_req, 0);
    step();
    chk("irq_req_lat", int_req, 1);
    do_sync();
    chk("irq_busy", busy, 1);
    chk("irq_vsel", vec_sel, 2'b00);
    chk("irq_id3", irq_id, 3);
    chk("irq_req_drop", int_req, 0);
    do_fetch();
    chk("irq_idle", busy, 0);
    irq_src = 8'h00;
    repeat (6) step();
    chk("irq_clr_pend", pending, 0);
    chk("irq_clr_req", int_req, 0);

    // ---------------- NMI over IRQ with I set ----------------
    I_flag  = 1'b1;
    irq_src = 8'h0C;
    nmi_in  = 1'b1;
    repeat (3) step();
    chk("nmi_pending", pending, 8'h0C);
    chk("nmi_i_eff", i_eff, 0);
    chk("nmi_req_early", int_req, 0);
    step();
    chk("nmi_req", int_req, 1);
    do_sync();
    chk("nmi_busy", busy, 1);
    chk("nmi_vsel", vec_sel, 2'b01);
    chk("nmi_id", irq_id, 0);
    chk("nmi_i_eff_taken", i_eff, 1);
    do_fetch();
    chk("nmi_done", busy, 0);
    chk("nmi_done_vsel", vec_sel, 2'b00);
    chk("nmi_done_req", int_req, 0);
    chk("nmi_done_i_eff", i_eff, 1);
    I_flag = 1'b0;
    step();
    chk("irq2_req", int_req, 1);
    do_sync();
    chk("irq2_id", irq_id, 2);
    chk("irq2_vsel", vec_sel, 2'b00);
    do_fetch();
    chk("irq2_done", busy, 0);
    nmi_in = 1'b0;
    I_flag = 1'b1;
    repeat (3) step();

    // ---------------- I gating holds IRQ off ----------------
    for (int i = 1; i <= 100; i++) begin
      step();
      if (i % 10 == 0) chk("igate_req", int_req, 0);
    end
    I_flag = 1'b0;
    step();
    chk("igate_release", int_req, 1);
    I_flag = 1'b1;
    step();

    // ---------------- timeout with NMI retry ----------------
    nmi_in = 1'b1;
    repeat (4) step();
    chk("to_req", int_req, 1);
    do_sync();
    chk("to_vsel", vec_sel, 2'b01);
    repeat (15) step();
    chk("to_still_busy", busy, 1);
    chk("to_not_yet", timeout, 0);
    step();
    chk("to_idle", busy, 0);
    chk("to_flag", timeout, 1);
    chk("to_vsel_after", vec_sel, 2'b00);
    chk("to_retry_req", int_req, 1);
    chk("to_retry_i_eff", i_eff, 0);

    // ---------------- NMI edge coincident with NMI fetch ----------------
    do_sync();
    chk("co_vsel", vec_sel, 2'b01);
    nmi_in = 1'b0;
    repeat (4) step();
    nmi_in = 1'b1;
    repeat (2) step();
    do_fetch();
    chk("co_idle", busy, 0);
    chk("co_i_eff", i_eff, 0);
    step();
    chk("co_req", int_req, 1);
    do_sync();
    chk("co_second_vsel", vec_sel, 2'b01);
    chk("co_second_busy", busy, 1);
    do_fetch();
    chk("co_second_done", busy, 0);
    chk("co_i_eff_after", i_eff, 1);
    chk("timeout_sticky", timeout, 1);

    // ---------------- reset mid-TAKEN ----------------
    I_flag = 1'b0;
    step();
    do_sync();
    chk("mid_busy", busy, 1);
    chk("mid_id", irq_id, 2);
    I_flag = 1'b1;
    reset  = 1'b1;
    step();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_vsel", vec_sel, 2'b10);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_i_eff", i_eff, 1);
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
